debug_capture: RTL

Downstream consumer of the change-detecting debugger stage. It timestamps every `trigger` pulse together with the 8-bit `data` word, buffers the resulting records in a small FIFO, and serializes each record as a 3-byte stream over a valid/ready byte interface. That interface feeds the Ethernet frame builder.

---
 rtl/debug_capture_pkg.sv | 15 +
 rtl/debug_fifo.sv | 53 +++++
 rtl/debug_capture.sv | 122 ++++++++++++
 3 files changed

// File: rtl/debug_capture_pkg.sv
// Shared types and record geometry for the debug capture path.
package debug_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TS_HI = 2'd1,
    TS_LO = 2'd2,
    DAT   = 2'd3
  } ser_state_t;

  localparam int REC_W     = 24;
  localparam int TS_W      = 16;
  localparam int REC_BYTES = 3;

endpackage

// File: rtl/debug_fifo.sv
// Single-clock first-word-fall-through FIFO; dout is valid whenever not empty.
module debug_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign rd_en = pop && !empty;
  // A push while full is still legal when the same cycle frees a slot.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/debug_capture.sv
// Timestamps trigger events, queues them, and streams each record as three bytes.
module debug_capture
  import debug_capture_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trigger,
  input  logic [7:0]              data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_last,
  output logic [7:0]              drop_count,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Byte 0 is the most significant byte of the record.
  function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec, input int idx);
    return rec[(REC_BYTES-1-idx)*8 +: 8];
  endfunction

  logic [TS_W-1:0]  ts_cnt;
  logic [REC_W-1:0] fifo_dout;
  logic [REC_W-1:0] hold_rec;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             push_ok;
  logic             drop;
  ser_state_t       state;

  assign fifo_pop = !fifo_empty && ((state == IDLE) || (state == DAT && tx_ready));
  assign push_ok  = trigger && (!fifo_full || fifo_pop);
  assign drop     = trigger && fifo_full && !fifo_pop;

  debug_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (fifo_pop),
    .din   ({ts_cnt, data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt     <= '0;
      drop_count <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (drop) drop_count <= sat_inc8(drop_count);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_pop) hold_rec <= fifo_dout;
  end

  // Serializer: outputs are registered and only advance on a handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state    <= TS_HI;
            tx_valid <= 1'b1;
            tx_data  <= rec_byte(fifo_dout, 0);
            tx_last  <= 1'b0;
          end
        end
        TS_HI: begin
          if (tx_ready) begin
            state   <= TS_LO;
            tx_data <= rec_byte(hold_rec, 1);
          end
        end
        TS_LO: begin
          if (tx_ready) begin
            state   <= DAT;
            tx_data <= rec_byte(hold_rec, 2);
            tx_last <= 1'b1;
          end
        end
        DAT: begin
          if (tx_ready) begin
            tx_last <= 1'b0;
            if (!fifo_empty) begin
              state   <= TS_HI;
              tx_data <= rec_byte(fifo_dout, 0);
            end else begin
              state    <= IDLE;
              tx_valid <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
